// File: rtl/interleaver_ctrl.sv
// interleaver_ctrl: block-interleaver SRAM address/control generator (row-major write, column-major read)
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   en_in    : input symbol valid; symbol on SRAM DIN is written this cycle
//   in_ready : symbol may be accepted (FILL state)
//   ADDR     : SRAM address, linear index r*N_COL+c
//   NCE      : SRAM chip enable, active low
//   NWRT     : SRAM write enable, active low
//   en_out   : interleaved symbol valid on SRAM DO
//   sof_out  : pulse with the first en_out of a frame
//   ovf      : sticky, en_in seen while in_ready=0
module interleaver_ctrl #(
   parameter int N_ROW = 12,
   parameter int N_COL = 128,
   parameter int AW    = 14
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_in,
   output logic          in_ready,
   output logic [AW-1:0] ADDR,
   output logic          NCE,
   output logic          NWRT,
   output logic          en_out,
   output logic          sof_out,
   output logic          ovf
);
   localparam int FS = N_ROW * N_COL;
   localparam int RW = N_ROW > 1 ? $clog2(N_ROW) : 1;
   localparam int CW = N_COL > 1 ? $clog2(N_COL) : 1;
   typedef enum logic {FILL, DRAIN} state_t;
   state_t        state, state_nx;
   logic [AW-1:0] wr_cnt, rd_addr;
   logic [RW-1:0] rd_row;
   logic [CW-1:0] rd_col;
   logic          last_wr, last_row, last_rd;
   assign last_wr  = en_in && wr_cnt == AW'(FS - 1);
   assign last_row = rd_row == RW'(N_ROW - 1);
   assign last_rd  = last_row && rd_col == CW'(N_COL - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= FILL;
      else     state <= state_nx;
   always_comb
      state_nx = (state == FILL) ? (last_wr ? DRAIN : FILL) : (last_rd ? FILL : DRAIN);
   // Write strobes follow en_in combinationally so the symbol on DIN lands in its own cycle.
   always_comb begin
      in_ready = state == FILL;
      NCE      = in_ready ? ~en_in : 1'b0;
      NWRT     = in_ready ? ~en_in : 1'b1;
      ADDR     = in_ready ? wr_cnt : rd_addr;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_cnt  <= '0;
         rd_addr <= '0;
         rd_row  <= '0;
         rd_col  <= '0;
         en_out  <= 1'b0;
         sof_out <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         en_out  <= state == DRAIN;
         sof_out <= state == DRAIN && rd_addr == '0;
         ovf     <= ovf | (en_in & ~in_ready);
         if (state == FILL && en_in)
            wr_cnt <= last_wr ? '0 : wr_cnt + 1'b1;
         // Column-major walk: step by N_COL down a column, then restart at the next column's top.
         if (state == DRAIN) begin
            if (last_rd) begin
               rd_row  <= '0;
               rd_col  <= '0;
               rd_addr <= '0;
            end else if (!last_row) begin
               rd_row  <= rd_row + 1'b1;
               rd_addr <= rd_addr + AW'(N_COL);
            end else begin
               rd_row  <= '0;
               rd_col  <= rd_col + 1'b1;
               rd_addr <= AW'(rd_col) + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_interleaver_ctrl.sv
// tb_interleaver_ctrl: scoreboard bench with SRAM model and frame-level reference model
module tb_interleaver_ctrl;
   localparam int N_ROW = 12;
   localparam int N_COL = 128;
   localparam int AW    = 14;
   localparam int FS    = N_ROW * N_COL;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en_in = 1'b0;
   logic          in_ready, NCE, NWRT, en_out, sof_out, ovf;
   logic [AW-1:0] ADDR;
   logic [15:0]   din = '0;
   logic [15:0]   do_q;
   logic [15:0]   mem [0:(1<<AW)-1];
   int            n_pass = 0, n_total = 0;
   int            frame [FS];
   int            exp_q [$];
   bit            m_fill = 1, m_rd_prev = 0, m_sof = 0, m_ovf = 0;
   int            m_wr = 0, m_k = 0, sof_cnt = 0;
   interleaver_ctrl #(.N_ROW(N_ROW), .N_COL(N_COL), .AW(AW)) dut (
      .clk(clk), .rst(rst), .en_in(en_in), .in_ready(in_ready), .ADDR(ADDR),
      .NCE(NCE), .NWRT(NWRT), .en_out(en_out), .sof_out(sof_out), .ovf(ovf)
   );
   always #5 clk = ~clk;
   always @(posedge clk)
      if (!NCE) begin
         if (!NWRT) mem[ADDR] <= din;
         else       do_q <= mem[ADDR];
      end
   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask
   always @(negedge clk) begin
      if (rst) begin
         m_fill = 1; m_rd_prev = 0; m_sof = 0; m_ovf = 0; m_wr = 0; m_k = 0;
         exp_q.delete();
      end else begin
         chk("in_ready", in_ready, m_fill);
         chk("en_out", en_out, m_rd_prev);
         chk("sof_out", sof_out, m_sof);
         chk("ovf", ovf, m_ovf);
         if (sof_out) sof_cnt++;
         if (en_out) begin
            chk("queue_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("dout", do_q, exp_q.pop_front());
         end
         if (m_fill) begin
            chk("fill_nce", NCE, !en_in);
            chk("fill_nwrt", NWRT, !en_in);
            chk("fill_addr", ADDR, m_wr);
         end else begin
            chk("drain_nce", NCE, 0);
            chk("drain_nwrt", NWRT, 1);
            chk("drain_addr", ADDR, (m_k % N_ROW) * N_COL + m_k / N_ROW);
         end
         m_rd_prev = !m_fill;
         m_sof = !m_fill && m_k == 0;
         if (m_fill) begin
            if (en_in) begin
               frame[m_wr] = din;
               m_wr++;
               if (m_wr == FS) begin
                  m_fill = 0; m_k = 0;
                  for (int k = 0; k < FS; k++)
                     exp_q.push_back(frame[(k % N_ROW) * N_COL + k / N_ROW]);
               end
            end
         end else begin
            if (en_in) m_ovf = 1;
            m_k++;
            if (m_k == FS) begin m_fill = 1; m_wr = 0; end
         end
      end
   end
   task automatic cyc();
      @(posedge clk); #1;
   endtask
   task automatic send_frame(input int gapmax, input bit seq);
      for (int i = 0; i < FS; i++) begin
         en_in = 0;
         repeat ($urandom_range(gapmax, 0)) cyc();
         en_in = 1;
         din = seq ? 16'(i % 2048) : 16'($urandom_range(65535, 0));
         cyc();
      end
      en_in = 0;
   endtask
   task automatic wait_fill();
      int n = 0;
      while (!m_fill && n < 5000) begin cyc(); n++; end
      chk("drain_timeout", m_fill, 1);
   endtask
   initial begin
      cyc(); cyc(); rst = 0;
      repeat (20) cyc();
      send_frame(0, 1);
      wait_fill();
      repeat (5) cyc();
      send_frame(5, 0);
      wait_fill();
      repeat (3) cyc();
      send_frame(0, 0);
      en_in = 1;
      while (!m_fill) begin din = 16'($urandom_range(65535, 0)); cyc(); end
      en_in = 0;
      repeat (10) cyc();
      send_frame(0, 0);
      begin
         int n = 0;
         while (m_k < 700 && n < 3000) begin cyc(); n++; end
         chk("reach_read_700", m_k, 700);
      end
      rst = 1;
      #1;
      chk("rst_en_out", en_out, 0);
      chk("rst_sof_out", sof_out, 0);
      chk("rst_nce", NCE, 1);
      chk("rst_nwrt", NWRT, 1);
      chk("rst_addr", ADDR, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_ovf", ovf, 0);
      cyc(); cyc(); rst = 0;
      repeat (5) cyc();
      send_frame(2, 0);
      wait_fill();
      repeat (5) cyc();
      sof_cnt = 0;
      send_frame(0, 0);
      wait_fill();
      send_frame(0, 1);
      wait_fill();
      repeat (5) cyc();
      chk("b2b_sof_count", sof_cnt, 2);
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
